// File: rtl/rvs192_pkg.sv
// RVS192 shared package: pipeline-control types and constants.
// Holds the FSM state enum, stage control bundle and drain length.
package rvs192_pkg;

  localparam int PC_W = 32;

  parameter int ISR_DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    VECTOR = 2'd2
  } pp_ctrl_state_type;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic kill_id;
    logic kill_ex;
    logic kill_mem;
  } stage_ctrl_type;

  // Canned control words, MSB = stall_if ... LSB = kill_mem.
  localparam stage_ctrl_type CTRL_NONE   = 7'b0000000;
  localparam stage_ctrl_type CTRL_FREEZE = 7'b1111000;
  localparam stage_ctrl_type CTRL_BRKILL = 7'b0000110;
  localparam stage_ctrl_type CTRL_LDUSE  = 7'b1100010;
  localparam stage_ctrl_type CTRL_IMISS  = 7'b1000100;
  localparam stage_ctrl_type CTRL_FLUSH  = 7'b1000111;
  localparam stage_ctrl_type CTRL_VEC    = 7'b0000100;

endpackage

// File: rtl/rvs192_hazard_detect.sv
// RVS192 load-use hazard compare between the EX load and ID sources.
// In: id_rs1, id_rs2, ex_rd, ex_cpu_read. Out: load_use (combinational).
module rvs192_hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_cpu_read,
  output logic       load_use
);

  logic rd_nz;
  logic hit;

  // x0 is never a real producer, so it cannot create a hazard.
  assign rd_nz = |ex_rd;
  assign hit   = (ex_rd == id_rs1) || (ex_rd == id_rs2);

  assign load_use = ex_cpu_read & rd_nz & hit;

endmodule

// File: rtl/rvs192_pipeline_ctrl.sv
// RVS192 central stall/kill sequencer with interrupt drain/redirect FSM.
// Config macro: RVS192_ISR_EN (undefined: no interrupt path, state RUN).
// In : clk, rst_n, id_rs1/2, ex_rd, ex_cpu_read, ex_valid, ex_pc,
//      ex_br_wrong, icache_stall, dcache_stall, irq_req, irq_vector.
// Out: stall_if/id/ex/mem, kill_id/ex/mem, pc_redirect, redirect_pc,
//      epc, irq_ack.
module rvs192_pipeline_ctrl
  import rvs192_pkg::*;
#(
  parameter int DRAIN_CYCLES = ISR_DRAIN_CYCLES,
  parameter int PC_LENGTH    = PC_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_cpu_read,
  input  logic                 ex_valid,
  input  logic [PC_LENGTH-1:0] ex_pc,
  input  logic                 ex_br_wrong,
  input  logic                 icache_stall,
  input  logic                 dcache_stall,
  input  logic                 irq_req,
  input  logic [PC_LENGTH-1:0] irq_vector,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_mem,
  output logic                 kill_id,
  output logic                 kill_ex,
  output logic                 kill_mem,
  output logic                 pc_redirect,
  output logic [PC_LENGTH-1:0] redirect_pc,
  output logic [PC_LENGTH-1:0] epc,
  output logic                 irq_ack
);

  localparam int CNT_W =
    (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);

  logic load_use;

  rvs192_hazard_detect u_hd (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_cpu_read (ex_cpu_read),
    .load_use    (load_use)
  );

  pp_ctrl_state_type    state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PC_LENGTH-1:0] epc_q, epc_d;
  stage_ctrl_type       ctrl;
  logic                 redir;
  logic                 ack;
  logic                 irq_go;

`ifdef RVS192_ISR_EN
  assign irq_go = irq_req & ex_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end
`else
  assign irq_go  = 1'b0;
  assign state_q = RUN;
  assign cnt_q   = '0;
  assign epc_q   = '0;

  logic unused_isr;
  assign unused_isr = ^{irq_req, ex_valid, ex_pc,
                        state_d, cnt_d, epc_d};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    ctrl    = CTRL_NONE;
    redir   = 1'b0;
    ack     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (dcache_stall) begin
          // Pending mispredict/load-use inputs persist under freeze.
          ctrl = CTRL_FREEZE;
        end else if (ex_br_wrong) begin
          ctrl = CTRL_BRKILL;
        end else if (irq_go) begin
          // Squash EX; it re-executes from epc after return.
          ctrl    = CTRL_FLUSH;
          state_d = DRAIN;
          cnt_d   = CNT_LOAD;
          epc_d   = ex_pc;
        end else if (load_use) begin
          ctrl = CTRL_LDUSE;
        end else if (icache_stall) begin
          ctrl = CTRL_IMISS;
        end
      end
      DRAIN: begin
        if (dcache_stall) begin
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl  = CTRL_FLUSH;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = VECTOR;
          end
        end
      end
      VECTOR: begin
        ctrl    = CTRL_VEC;
        redir   = 1'b1;
        ack     = 1'b1;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Everything reads as idle while reset is held.
  assign stall_if    = rst_n & ctrl.stall_if;
  assign stall_id    = rst_n & ctrl.stall_id;
  assign stall_ex    = rst_n & ctrl.stall_ex;
  assign stall_mem   = rst_n & ctrl.stall_mem;
  assign kill_id     = rst_n & ctrl.kill_id;
  assign kill_ex     = rst_n & ctrl.kill_ex;
  assign kill_mem    = rst_n & ctrl.kill_mem;
  assign pc_redirect = rst_n & redir;
  assign irq_ack     = rst_n & ack;
  assign redirect_pc = irq_vector;
  assign epc         = epc_q;

endmodule

// File: tb/tb_rvs192_pipeline_ctrl.sv
// Directed self-checking bench for rvs192_pipeline_ctrl.
// Covers hazards, priority, dcache freeze and the interrupt sequence.
module tb_rvs192_pipeline_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_cpu_read, ex_valid;
  logic [31:0] ex_pc;
  logic        ex_br_wrong, icache_stall, dcache_stall;
  logic        irq_req;
  logic [31:0] irq_vector;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        kill_id, kill_ex, kill_mem;
  logic        pc_redirect, irq_ack;
  logic [31:0] redirect_pc, epc;

  int total = 0;
  int bad   = 0;

  rvs192_pipeline_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_rd        (ex_rd),
    .ex_cpu_read  (ex_cpu_read),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_br_wrong  (ex_br_wrong),
    .icache_stall (icache_stall),
    .dcache_stall (dcache_stall),
    .irq_req      (irq_req),
    .irq_vector   (irq_vector),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .kill_id      (kill_id),
    .kill_ex      (kill_ex),
    .kill_mem     (kill_mem),
    .pc_redirect  (pc_redirect),
    .redirect_pc  (redirect_pc),
    .epc          (epc),
    .irq_ack      (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] ctl;
  assign ctl = {stall_if, stall_id, stall_ex, stall_mem,
                kill_id, kill_ex, kill_mem};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_FRZ  = 7'b1111000;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_IM   = 7'b1000100;
  localparam logic [6:0] C_FL   = 7'b1000111;
  localparam logic [6:0] C_VEC  = 7'b0000100;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    ex_cpu_read = 0; ex_valid = 0; ex_pc = 0;
    ex_br_wrong = 0; icache_stall = 0; dcache_stall = 0;
    irq_req = 0;
  endtask

  int hits;

  initial begin
    idle();
    irq_vector = 32'h0000_0400;
    rst_n = 1'b0;
    dcache_stall = 1'b1;
    ex_br_wrong  = 1'b1;
    smp();
    chk("rst_ctl",   ctl, C_NONE);
    chk("rst_redir", pc_redirect, 0);
    chk("rst_ack",   irq_ack, 0);
    chk("rst_epc",   epc, 0);
    chk("rst_rpc",   redirect_pc, 32'h400);
    nxt();
    idle();
    rst_n = 1'b1;
    nxt();

    smp(); chk("idle", ctl, C_NONE); nxt();

    ex_cpu_read = 1; ex_rd = 5; id_rs1 = 5; id_rs2 = 7;
    smp(); chk("lu_rs1", ctl, C_LU); nxt();

    id_rs1 = 3; id_rs2 = 5;
    smp(); chk("lu_rs2", ctl, C_LU); nxt();

    ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    smp(); chk("lu_x0", ctl, C_NONE); nxt();

    ex_cpu_read = 0; ex_rd = 5; id_rs1 = 5;
    smp(); chk("no_load", ctl, C_NONE); nxt();

    ex_cpu_read = 1; ex_br_wrong = 1;
    smp(); chk("br_over_lu", ctl, C_BR); nxt();

    ex_br_wrong = 0; ex_cpu_read = 0; icache_stall = 1;
    smp(); chk("imiss", ctl, C_IM); nxt();

    ex_cpu_read = 1;
    smp(); chk("lu_over_im", ctl, C_LU); nxt();

    idle();
    ex_br_wrong = 1; dcache_stall = 1;
    for (int i = 0; i < 3; i++) begin
      smp(); chk($sformatf("dfrz%0d", i), ctl, C_FRZ); nxt();
    end
    dcache_stall = 0;
    smp(); chk("br_after_d", ctl, C_BR); nxt();
    idle();

`ifdef RVS192_ISR_EN
    ex_valid = 1; irq_req = 1; ex_pc = 32'h120; ex_br_wrong = 1;
    smp(); chk("irq_br_pri", ctl, C_BR); nxt();
    ex_br_wrong = 0; ex_valid = 0;
    smp(); chk("irq_noval", ctl, C_NONE); nxt();

    ex_valid = 1;
    smp();
    chk("acc_ctl", ctl, C_FL);
    chk("acc_redir", pc_redirect, 0);
    nxt();
    idle();
    smp();
    chk("dr1_ctl", ctl, C_FL);
    chk("dr1_epc", epc, 32'h120);
    chk("dr1_redir", pc_redirect, 0);
    nxt();
    ex_br_wrong = 1; icache_stall = 1;
    smp();
    chk("dr2_ctl", ctl, C_FL);
    chk("dr2_redir", pc_redirect, 0);
    nxt();
    smp();
    chk("vec_redir", pc_redirect, 1);
    chk("vec_ack", irq_ack, 1);
    chk("vec_rpc", redirect_pc, 32'h400);
    chk("vec_ctl", ctl, C_VEC);
    nxt();
    idle();
    smp();
    chk("post_redir", pc_redirect, 0);
    chk("post_ack", irq_ack, 0);
    chk("post_ctl", ctl, C_NONE);
    nxt();

    ex_valid = 1; irq_req = 1; ex_pc = 32'h200;
    smp(); chk("acc2_ctl", ctl, C_FL); nxt();
    idle();
    smp(); chk("d2_1", ctl, C_FL); nxt();
    dcache_stall = 1;
    smp(); chk("d2_frz0", ctl, C_FRZ); nxt();
    smp(); chk("d2_frz1", ctl, C_FRZ); nxt();
    dcache_stall = 0;
    smp();
    chk("d2_2", ctl, C_FL);
    chk("d2_2_redir", pc_redirect, 0);
    nxt();
    smp();
    chk("d2_vec", pc_redirect, 1);
    chk("d2_epc", epc, 32'h200);
    nxt();

    ex_valid = 1; irq_req = 1; ex_pc = 32'h300;
    smp(); nxt();
    idle();
    smp(); chk("r_dr", ctl, C_FL); nxt();
    #2 rst_n = 1'b0;
    #1;
    chk("r_ctl", ctl, C_NONE);
    chk("r_epc", epc, 0);
    chk("r_redir", pc_redirect, 0);
    nxt();
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      smp();
      if (pc_redirect || irq_ack || ctl != C_NONE) hits++;
      nxt();
    end
    chk("r_quiet", hits, 0);
`else
    ex_valid = 1; irq_req = 1; ex_pc = 32'h120;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (pc_redirect || irq_ack || ctl != C_NONE) hits++;
      nxt();
    end
    chk("noisr_quiet", hits, 0);
    chk("noisr_epc", epc, 0);
    ex_cpu_read = 1; ex_rd = 9; id_rs2 = 9;
    smp(); chk("noisr_lu", ctl, C_LU); nxt();
    idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
